// File: rtl/icache_pkg.sv
// icache_pkg: shared sizing constants and state type for the icache refill controller
package icache_pkg;
  localparam int B = 64;
  localparam int MEM_W = 32;
  localparam int REP_W = 64;
  localparam int WORDS = B / 4;
  localparam int BEATS = B / 8;
  localparam int OFF_W = $clog2(B);
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} refill_state_t;
endpackage

// File: rtl/refill_packer.sv
// refill_packer: pairs 32-bit memory beats into 64-bit replacement words with a one-cycle ready pulse
module refill_packer
  import icache_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             beat_i,
  input  logic             flush_i,
  input  logic             odd_i,
  input  logic             last_i,
  input  logic [MEM_W-1:0] rdata_i,
  output logic [REP_W-1:0] rep_word_o,
  output logic             rep_ready_o,
  output logic             fill_done_o
);
  logic [MEM_W-1:0] lo;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      lo <= '0;
      rep_word_o <= '0;
      rep_ready_o <= 1'b0;
      fill_done_o <= 1'b0;
    end else begin
      rep_ready_o <= beat_i && odd_i && !flush_i;
      fill_done_o <= beat_i && last_i && !flush_i;
      if (beat_i && !odd_i) lo <= rdata_i;
      if (beat_i && odd_i && !flush_i) rep_word_o <= {rdata_i, lo};
    end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 I-cache miss refill engine issuing one burst read per block miss
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             miss_valid_i,
  input  logic [31:0]      miss_addr_i,
  output logic             miss_ready_o,
  input  logic             abort_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [MEM_W-1:0] mem_rdata_i,
  output logic [REP_W-1:0] rep_word_o,
  output logic             rep_ready_o,
  output logic             fill_done_o,
  output logic             busy_o
);
  refill_state_t state;
  logic [CNT_W-1:0] word_cnt;
  logic [31:0] base;
  logic fill_beat;
  assign miss_ready_o = state == IDLE;
  assign mem_req_o = state == REQ;
  assign mem_addr_o = base;
  assign busy_o = state != IDLE;
  // the final pulse cycle is still FILL; beats arriving then are out of protocol
  assign fill_beat = state == FILL && mem_rvalid_i && !fill_done_o;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state <= IDLE;
      word_cnt <= '0;
      base <= '0;
    end else begin
      unique case (state)
        IDLE: if (miss_valid_i && !abort_i) begin
          base <= {miss_addr_i[31:OFF_W], {OFF_W{1'b0}}};
          state <= REQ;
        end
        REQ: if (mem_gnt_i) begin
          state <= abort_i ? DRAIN : FILL;
          word_cnt <= '0;
        end else if (abort_i) state <= IDLE;
        FILL: if (fill_done_o) begin
          state <= IDLE;
          word_cnt <= '0;
        end else if (abort_i && mem_rvalid_i && word_cnt == LAST_WORD) begin
          state <= IDLE;
          word_cnt <= '0;
        end else begin
          if (mem_rvalid_i && word_cnt != LAST_WORD) word_cnt <= word_cnt + 1'b1;
          if (abort_i) state <= DRAIN;
        end
        DRAIN: if (mem_rvalid_i) begin
          word_cnt <= word_cnt == LAST_WORD ? '0 : word_cnt + 1'b1;
          state <= word_cnt == LAST_WORD ? IDLE : DRAIN;
        end
      endcase
    end
  refill_packer u_packer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .beat_i      (fill_beat),
    .flush_i     (abort_i),
    .odd_i       (word_cnt[0]),
    .last_i      (word_cnt == LAST_WORD),
    .rdata_i     (mem_rdata_i),
    .rep_word_o  (rep_word_o),
    .rep_ready_o (rep_ready_o),
    .fill_done_o (fill_done_o)
  );
endmodule
